// File: rtl/weight_buf_pkg.sv
// Shared types and sizing helpers for the weight ping-pong buffer.
//   rd_state_t : read-side FSM states
//   cnt_w()    : width of a per-bank column count (0..NUM_COLS)
//   ptr_w()    : width of a column slot pointer (at least 1 bit)
//   wcol_t     : weight column at the default geometry
package weight_buf_pkg;

  typedef enum logic {RD_IDLE, RD_STREAM} rd_state_t;

  localparam int DEF_ROWS  = 96;
  localparam int DEF_WIDTH = 5;

  typedef logic [0:DEF_ROWS-1][DEF_WIDTH-1:0] wcol_t;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int ptr_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/weight_bank_store.sv
// One bank of NUM_COLS weight columns.
//   clk, reset : clock, async active-low clear of every column
//   we, widx, wdata : write one column at slot widx
//   ridx, rdata     : combinational read of slot ridx
module weight_bank_store
  import weight_buf_pkg::*;
#(
  parameter int ROWS     = 96,
  parameter int WIDTH    = 5,
  parameter int NUM_COLS = 8,
  parameter int PTR_W    = ptr_w(NUM_COLS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        we,
  input  logic [PTR_W-1:0]            widx,
  input  logic [0:ROWS-1][WIDTH-1:0]  wdata,
  input  logic [PTR_W-1:0]            ridx,
  output logic [0:ROWS-1][WIDTH-1:0]  rdata
);

  logic [NUM_COLS-1:0][0:ROWS-1][WIDTH-1:0] mem;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  mem <= '0;
    else if (we) mem[widx] <= wdata;
  end

  // Guard slots past NUM_COLS when it is not a power of two.
  always_comb begin
    rdata = '0;
    if (int'(ridx) < NUM_COLS) rdata = mem[ridx];
  end

endmodule

// File: rtl/weight_pingpong_buffer.sv
// Double-buffered weight store for the systolic array weight-load path.
// The loader fills one bank while the array streams the other; a bank can
// be kept resident (replay) and re-streamed for several input tiles.
//   clk, reset                 : clock, async active-low reset
//   wr_valid/wr_ready/wr_col   : column write handshake
//   wr_last                    : closes a short tile
//   rd_start                   : level request to stream the read bank
//   rd_replay                  : sampled on the final beat, keeps the bank
//   rd_valid/rd_ready/rd_col   : column stream handshake
//   rd_last                    : final column of the tile
//   bank_full                  : per-bank full flag
module weight_pingpong_buffer
  import weight_buf_pkg::*;
#(
  parameter int WEIGHT_ROWS  = 96,
  parameter int WEIGHT_WIDTH = 5,
  parameter int NUM_COLS     = 8
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     wr_valid,
  output logic                                     wr_ready,
  input  logic [0:WEIGHT_ROWS-1][WEIGHT_WIDTH-1:0] wr_col,
  input  logic                                     wr_last,
  input  logic                                     rd_start,
  input  logic                                     rd_replay,
  output logic                                     rd_valid,
  input  logic                                     rd_ready,
  output logic [0:WEIGHT_ROWS-1][WEIGHT_WIDTH-1:0] rd_col,
  output logic                                     rd_last,
  output logic [1:0]                               bank_full
);

  localparam int CNT_W = cnt_w(NUM_COLS);
  localparam int PTR_W = ptr_w(NUM_COLS);
  localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(NUM_COLS - 1);

  typedef logic [0:WEIGHT_ROWS-1][WEIGHT_WIDTH-1:0] col_t;

  logic [1:0]            full;
  logic [1:0][CNT_W-1:0] cnt;
  logic                  wr_bank, rd_bank;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  rd_state_t             rd_state, rd_state_nx;
  col_t [1:0]            bank_rdata;
  logic [1:0]            bank_we;

  logic wr_fire, wr_close, rd_beat, rd_done, rd_release;
  logic [1:0] full_set, full_clr;

  // ---------------- write side ----------------
  assign wr_ready = !full[wr_bank];
  assign wr_fire  = wr_valid && wr_ready;
  assign wr_close = wr_fire && (wr_last || wr_ptr == LAST_SLOT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_bank <= 1'b0;
      wr_ptr  <= '0;
      cnt     <= '0;
    end else if (wr_fire) begin
      if (wr_close) begin
        cnt[wr_bank] <= CNT_W'(wr_ptr) + CNT_W'(1);
        wr_bank      <= ~wr_bank;
        wr_ptr       <= '0;
      end else begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
    end
  end

  // ---------------- bank storage ----------------
  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign bank_we[b] = wr_fire && (wr_bank == 1'(b));

    weight_bank_store #(
      .ROWS     (WEIGHT_ROWS),
      .WIDTH    (WEIGHT_WIDTH),
      .NUM_COLS (NUM_COLS),
      .PTR_W    (PTR_W)
    ) u_store (
      .clk   (clk),
      .reset (reset),
      .we    (bank_we[b]),
      .widx  (wr_ptr),
      .wdata (wr_col),
      .ridx  (rd_ptr),
      .rdata (bank_rdata[b])
    );
  end

  // ---------------- read FSM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd_state <= RD_IDLE;
    else        rd_state <= rd_state_nx;
  end

  always_comb begin
    rd_state_nx = rd_state;
    rd_valid    = 1'b0;
    rd_col      = '0;
    rd_last     = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        // rd_start is a level; it is simply not acted on until the bank fills.
        if (rd_start && full[rd_bank]) rd_state_nx = RD_STREAM;
      end
      RD_STREAM: begin
        rd_valid = 1'b1;
        rd_col   = bank_rdata[rd_bank];
        rd_last  = (CNT_W'(rd_ptr) == cnt[rd_bank] - CNT_W'(1));
        if (rd_ready && rd_last) rd_state_nx = RD_IDLE;
      end
      default: rd_state_nx = RD_IDLE;
    endcase
  end

  assign rd_beat    = rd_valid && rd_ready;
  assign rd_done    = rd_beat && rd_last;
  assign rd_release = rd_done && !rd_replay;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr  <= '0;
      rd_bank <= 1'b0;
    end else if (rd_done) begin
      rd_ptr <= '0;
      if (!rd_replay) rd_bank <= ~rd_bank;
    end else if (rd_beat) begin
      rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // ---------------- full flags ----------------
  // Set and clear can never hit the same bank in one cycle: the writer only
  // targets a non-full bank and the reader only releases a full one.
  assign full_set = {wr_close &&  wr_bank, wr_close && !wr_bank};
  assign full_clr = {rd_release &&  rd_bank, rd_release && !rd_bank};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) full <= '0;
    else        full <= (full | full_set) & ~full_clr;
  end

  assign bank_full = full;

endmodule

// File: tb/tb_weight_pingpong_buffer.sv
module tb_weight_pingpong_buffer;

  localparam int ROWS = 4, WIDTH = 5, COLS = 4;

  typedef logic [0:ROWS-1][WIDTH-1:0] col_t;
  typedef struct packed { col_t col; logic last; } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_valid = 1'b0, wr_ready, wr_last = 1'b0;
  col_t       wr_col = '0, rd_col;
  logic       rd_start = 1'b0, rd_replay = 1'b0, rd_valid, rd_ready = 1'b0, rd_last;
  logic [1:0] bank_full;

  int   checks = 0, errors = 0;
  int   tb_wptr = 0;
  exp_t sb[$];

  weight_pingpong_buffer #(
    .WEIGHT_ROWS(ROWS), .WEIGHT_WIDTH(WIDTH), .NUM_COLS(COLS)
  ) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_col(wr_col), .wr_last(wr_last),
    .rd_start(rd_start), .rd_replay(rd_replay),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_col(rd_col), .rd_last(rd_last),
    .bank_full(bank_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic col_t mk(input int v);
    col_t c;
    for (int r = 0; r < ROWS; r++) c[r] = 5'(v + 3 * r);
    return c;
  endfunction

  // Read-side scoreboard: every beat pops one expected column; a stalled
  // column must hold until it is taken.
  logic held = 1'b0;
  col_t h_col;
  logic h_last;
  always @(negedge clk) begin
    if (!reset) begin
      held = 1'b0;
    end else begin
      if (held && rd_valid) begin
        chk("stall_col", 64'(rd_col), 64'(h_col));
        chk("stall_last", 64'(rd_last), 64'(h_last));
      end
      if (!rd_valid) chk("idle_col", 64'(rd_col), 64'(0));
      if (rd_valid && rd_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", 64'(1), 64'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rd_col", 64'(rd_col), 64'(e.col));
          chk("rd_last", 64'(rd_last), 64'(e.last));
        end
        held = 1'b0;
      end else if (rd_valid) begin
        held = 1'b1; h_col = rd_col; h_last = rd_last;
      end else begin
        held = 1'b0;
      end
    end
  end

  task automatic wr(input int v, input bit last);
    bit ok;
    int n;
    exp_t e;
    wr_valid = 1'b1; wr_col = mk(v); wr_last = last; n = 0; ok = 1'b0;
    do begin
      @(negedge clk); ok = wr_ready;
      @(posedge clk); #1; n++;
    end while (!ok && n < 200);
    chk("wr_accept", 64'(ok), 64'(1));
    if (ok) begin
      e.col = mk(v);
      e.last = last || (tb_wptr == COLS - 1);
      sb.push_back(e);
      tb_wptr = e.last ? 0 : tb_wptr + 1;
    end
    wr_valid = 1'b0; wr_last = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    rd_start = 0; rd_ready = 0; rd_replay = 0; wr_valid = 0; wr_last = 0; wr_col = '0;
    sb.delete(); tb_wptr = 0;
    @(negedge clk);
    chk("rst_rd_valid", 64'(rd_valid), 64'(0));
    chk("rst_rd_last", 64'(rd_last), 64'(0));
    chk("rst_bank_full", 64'(bank_full), 64'(0));
    chk("rst_wr_ready", 64'(wr_ready), 64'(1));
    chk("rst_rd_col", 64'(rd_col), 64'(0));
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic wait_last(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = rd_valid && rd_ready && rd_last;
    end
    chk(tag, 64'(seen), 64'(1));
  endtask

  task automatic wait_empty(input string tag);
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    chk(tag, 64'(sb.size()), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- 1: reset, then reset in the middle of a stream ----
    do_reset();
    for (int i = 1; i <= 4; i++) wr(i, 1'b0);
    rd_start = 1'b1; rd_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("t1_streaming", 64'(rd_valid), 64'(1));
    do_reset();

    // ---- 2: full tile, no stalls, read concurrently enabled ----
    rd_start = 1'b1; rd_ready = 1'b1;
    for (int i = 1; i <= 4; i++) wr(i, 1'b0);
    @(negedge clk);
    chk("t2_full_after_w4", 64'(bank_full), 64'(2'b01));
    wait_empty("t2_drain");
    @(negedge clk);
    chk("t2_released", 64'(bank_full), 64'(2'b00));

    // ---- 3: both banks full, backpressure, ping-pong refill ----
    do_reset();
    for (int i = 1; i <= 8; i++) wr(i, 1'b0);
    @(negedge clk);
    chk("t3_both_full", 64'(bank_full), 64'(2'b11));
    chk("t3_wr_blocked", 64'(wr_ready), 64'(0));
    rd_start = 1'b1; rd_ready = 1'b1; rd_replay = 1'b0;
    fork
      wr(9, 1'b1);
      begin
        wait_last("t3_bank0_last");
        chk("t3_ready_on_last", 64'(wr_ready), 64'(0));
        @(negedge clk);
        chk("t3_ready_after", 64'(wr_ready), 64'(1));
      end
    join
    wait_empty("t3_drain");
    rd_start = 1'b0;
    @(negedge clk);
    chk("t3_all_released", 64'(bank_full), 64'(2'b00));

    // ---- 4: short tile of two columns ----
    do_reset();
    wr(7, 1'b0);
    wr(9, 1'b1);
    @(negedge clk);
    chk("t4_full", 64'(bank_full), 64'(2'b01));
    rd_start = 1'b1; rd_ready = 1'b1;
    wait_empty("t4_drain");
    rd_start = 1'b0;
    @(negedge clk);
    chk("t4_released", 64'(bank_full), 64'(2'b00));

    // ---- 5: replay twice, then release ----
    do_reset();
    for (int i = 11; i <= 14; i++) wr(i, 1'b0);
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 4; i++) sb.push_back(sb[i]);
    rd_replay = 1'b1; rd_start = 1'b1; rd_ready = 1'b1;
    wait_last("t5_pass1");
    @(negedge clk);
    chk("t5_kept1", 64'(bank_full), 64'(2'b01));
    wait_last("t5_pass2");
    @(posedge clk); #1;
    rd_replay = 1'b0;
    @(negedge clk);
    chk("t5_kept2", 64'(bank_full), 64'(2'b01));
    wait_last("t5_pass3");
    @(posedge clk); #1;
    rd_start = 1'b0;
    @(negedge clk);
    chk("t5_released", 64'(bank_full), 64'(2'b00));
    wait_empty("t5_drain");

    // ---- 6: read stalls with concurrent writes into the other bank ----
    do_reset();
    for (int i = 21; i <= 24; i++) wr(i, 1'b0);
    rd_start = 1'b1;
    fork
      for (int i = 31; i <= 34; i++) wr(i, 1'b0);
      begin
        logic [3:0] pat;
        pat = 4'b1001;
        for (int k = 0; k < 24; k++) begin
          rd_ready = pat[3 - (k % 4)];
          @(posedge clk); #1;
        end
      end
    join
    rd_ready = 1'b1;
    wait_empty("t6_drain");
    rd_start = 1'b0;
    @(negedge clk);
    chk("t6_released", 64'(bank_full), 64'(2'b00));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
